// File: rtl/conv_line_buffer.sv
// Line buffer producing five vertically aligned taps (current row plus four stored rows) for a 5x5 convolution.
// Optional macro LB_BORDER_REPLICATE_EN: replicate the top-edge row into missing taps instead of zero fill.
module conv_line_buffer #(
  parameter int COLORDEPTH  = 8,
  parameter int SCREENWIDTH = 1600,
  parameter int M_DEPTH     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] pix_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [COLORDEPTH-1:0] vect_out_0,
  output logic [COLORDEPTH-1:0] vect_out_1,
  output logic [COLORDEPTH-1:0] vect_out_2,
  output logic [COLORDEPTH-1:0] vect_out_3,
  output logic [COLORDEPTH-1:0] vect_out_4,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  line_end_o
);

  localparam int NROWS = M_DEPTH - 1;
  localparam int AW    = (SCREENWIDTH > 1) ? $clog2(SCREENWIDTH) : 1;
  localparam int CW    = $clog2(SCREENWIDTH + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(SCREENWIDTH);

  logic [COLORDEPTH-1:0] mem_r [4][SCREENWIDTH];
  logic [COLORDEPTH-1:0] vect_r [5];
  logic [CW-1:0]         wr_col_r;
  logic [1:0]            wr_sel_r;
  logic [2:0]            rows_filled_r;
  logic                  dv_q_r;
  logic                  hs_r;
  logic                  vs_q_r;
  logic                  line_end_r;
  logic                  discard_r;

  logic [AW-1:0]         addr_s;
  logic                  in_range_s;
  logic                  line_end_s;
  logic                  frame_start_s;
  logic [COLORDEPTH-1:0] rd_s [4];
  logic [COLORDEPTH-1:0] tap_s [5];
  logic [COLORDEPTH-1:0] fill_s;
  logic [COLORDEPTH-1:0] ovf_fill_s;

  // Read all line memories at the write column and select each tap by row age.
  always_comb begin
    addr_s        = wr_col_r[AW-1:0];
    in_range_s    = (wr_col_r < COL_MAX);
    line_end_s    = dv_q_r & ~dv_i;
    frame_start_s = vs_i & ~vs_q_r;
    for (int m = 0; m < 4; m++) begin
      rd_s[m] = mem_r[m][addr_s];
    end
`ifdef LB_BORDER_REPLICATE_EN
    // Missing rows copy the oldest row that is valid; with no rows stored that is the live pixel.
    if (rows_filled_r == 3'd0) begin
      fill_s = pix_i;
    end else begin
      fill_s = rd_s[wr_sel_r - rows_filled_r[1:0]];
    end
    ovf_fill_s = pix_i;
`else
    fill_s     = '0;
    ovf_fill_s = '0;
`endif
    tap_s[0] = pix_i;
    for (int k = 1; k < 5; k++) begin
      tap_s[k] = '0;
      if (!in_range_s) begin
        tap_s[k] = ovf_fill_s;
      end else if (3'(k) <= rows_filled_r) begin
        tap_s[k] = rd_s[wr_sel_r - 2'(k)];
      end else begin
        tap_s[k] = fill_s;
      end
    end
  end

  // Line memory write; read-first comes from the registered tap capture below.
  always_ff @(posedge clk) begin
    if (dv_i && in_range_s) begin
      mem_r[wr_sel_r][addr_s] <= pix_i;
    end
  end

  // Column/row bookkeeping, tap registers and delayed timing strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_col_r      <= '0;
      wr_sel_r      <= 2'd0;
      rows_filled_r <= 3'd0;
      dv_q_r        <= 1'b0;
      hs_r          <= 1'b0;
      vs_q_r        <= 1'b0;
      line_end_r    <= 1'b0;
      discard_r     <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        vect_r[k] <= '0;
      end
    end else begin
      dv_q_r     <= dv_i;
      hs_r       <= hs_i;
      vs_q_r     <= vs_i;
      line_end_r <= line_end_s;
      if (dv_i) begin
        for (int k = 0; k < 5; k++) begin
          vect_r[k] <= tap_s[k];
        end
      end
      // A frame start inside active video leaves a partial line that must not count as a row.
      if (frame_start_s) begin
        wr_col_r      <= '0;
        wr_sel_r      <= 2'd0;
        rows_filled_r <= 3'd0;
        discard_r     <= dv_i;
      end else if (line_end_s) begin
        wr_col_r  <= '0;
        discard_r <= 1'b0;
        if (!discard_r) begin
          wr_sel_r <= wr_sel_r + 2'd1;
          if (rows_filled_r < 3'(NROWS)) begin
            rows_filled_r <= rows_filled_r + 3'd1;
          end
        end
      end else if (dv_i && in_range_s) begin
        wr_col_r <= wr_col_r + CW'(1);
      end
    end
  end

  assign vect_out_0 = vect_r[0];
  assign vect_out_1 = vect_r[1];
  assign vect_out_2 = vect_r[2];
  assign vect_out_3 = vect_r[3];
  assign vect_out_4 = vect_r[4];
  assign dv_o       = dv_q_r;
  assign hs_o       = hs_r;
  assign vs_o       = vs_q_r;
  assign line_end_o = line_end_r;

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer with SCREENWIDTH=8; pixel value is 16*row+col.
module tb_conv_line_buffer;

  localparam int SW = 8;
`ifdef LB_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_i;
  logic       dv_i, hs_i, vs_i;
  logic [7:0] vect_out_0, vect_out_1, vect_out_2, vect_out_3, vect_out_4;
  logic       dv_o, hs_o, vs_o, line_end_o;
  logic [7:0] taps_w [5];

  int n_cmp  = 0;
  int n_fail = 0;

  conv_line_buffer #(.COLORDEPTH(8), .SCREENWIDTH(SW), .M_DEPTH(5)) dut (
    .clk(clk), .rst(rst), .pix_i(pix_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .vect_out_0(vect_out_0), .vect_out_1(vect_out_1), .vect_out_2(vect_out_2),
    .vect_out_3(vect_out_3), .vect_out_4(vect_out_4),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .line_end_o(line_end_o)
  );

  assign taps_w[0] = vect_out_0;
  assign taps_w[1] = vect_out_1;
  assign taps_w[2] = vect_out_2;
  assign taps_w[3] = vect_out_3;
  assign taps_w[4] = vect_out_4;

  always #5 clk = ~clk;

  function automatic int rep(input int v);
    return REP ? v : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_taps(input string tag, input int e0, input int e1, input int e2,
                          input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_t%0d", tag, k), {24'd0, taps_w[k]}, e[k]);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk_taps(tag, 0, 0, 0, 0, 0);
    chk({tag, "_dv"}, {31'd0, dv_o}, 32'd0);
    chk({tag, "_hs"}, {31'd0, hs_o}, 32'd0);
    chk({tag, "_vs"}, {31'd0, vs_o}, 32'd0);
    chk({tag, "_le"}, {31'd0, line_end_o}, 32'd0);
  endtask

  task automatic step(input logic [7:0] p, input logic d, input logic h, input logic v);
    pix_i = p; dv_i = d; hs_i = h; vs_i = v;
    @(posedge clk);
    #1;
  endtask

  // One line of npix pixels then two blank cycles; checks taps at column cc and overflow columns.
  task automatic send_line(input int row, input int npix, input int cc, input int e0,
                           input int e1, input int e2, input int e3, input int e4);
    logic [7:0] p;
    for (int c = 0; c < npix; c++) begin
      p = 8'(16 * row + c);
      step(p, 1'b1, 1'b0, 1'b0);
      if (c == cc) begin
        chk_taps($sformatf("L%0d_c%0d", row, c), e0, e1, e2, e3, e4);
        chk($sformatf("L%0d_c%0d_dv", row, c), {31'd0, dv_o}, 32'd1);
      end
      if (c >= SW) begin
        chk_taps($sformatf("ovf_L%0d_c%0d", row, c), int'(p), rep(int'(p)), rep(int'(p)),
                 rep(int'(p)), rep(int'(p)));
      end
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pix_i = 8'd0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    step(8'd0, 1'b0, 1'b0, 1'b0);

    // Fill six lines; check partial fill and the fully filled steady state.
    send_line(0, 8, -1, 0, 0, 0, 0, 0);
    send_line(1, 8, 2, 'h12, 'h02, rep('h02), rep('h02), rep('h02));
    send_line(2, 8, 7, 'h27, 'h17, 'h07, rep('h07), rep('h07));
    send_line(3, 8, -1, 0, 0, 0, 0, 0);
    send_line(4, 8, -1, 0, 0, 0, 0, 0);
    send_line(5, 8, 3, 'h53, 'h43, 'h33, 'h23, 'h13);

    // Line end pulse, strobe delays and hold while dv is low.
    for (int c = 0; c < 8; c++) step(8'(16 * 6 + c), 1'b1, 1'b0, 1'b0);
    chk_taps("L6_c7", 'h67, 'h57, 'h47, 'h37, 'h27);
    chk("L6_last_le", {31'd0, line_end_o}, 32'd0);
    chk("L6_last_hs", {31'd0, hs_o}, 32'd0);
    step(8'hAA, 1'b0, 1'b1, 1'b0);
    chk("le_pulse", {31'd0, line_end_o}, 32'd1);
    chk("le_dv_o", {31'd0, dv_o}, 32'd0);
    chk("le_hs_o", {31'd0, hs_o}, 32'd1);
    chk("hold_v0", {24'd0, vect_out_0}, 32'h67);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    chk("le_end", {31'd0, line_end_o}, 32'd0);
    chk("hs_fall", {31'd0, hs_o}, 32'd0);
    chk("vs_rise", {31'd0, vs_o}, 32'd1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    chk("vs_fall", {31'd0, vs_o}, 32'd0);

    // New frame: first row has no stored rows; then an over-long line.
    send_line(0, 8, 2, 'h02, rep('h02), rep('h02), rep('h02), rep('h02));
    send_line(1, 10, 7, 'h17, 'h07, rep('h07), rep('h07), rep('h07));
    send_line(2, 8, 7, 'h27, 'h17, 'h07, rep('h07), rep('h07));

    // vsync rises in the middle of line 3: the partial line is not a row.
    for (int c = 0; c < 3; c++) step(8'(16 * 3 + c), 1'b1, 1'b0, 1'b0);
    for (int c = 3; c < 8; c++) step(8'(16 * 3 + c), 1'b1, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    send_line(4, 8, 2, 'h42, rep('h42), rep('h42), rep('h42), rep('h42));
    send_line(5, 8, 2, 'h52, 'h42, rep('h42), rep('h42), rep('h42));

    // Fresh frame, four full rows, then async reset in the middle of line 4.
    step(8'd0, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) send_line(r, 8, -1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) step(8'(16 * 4 + c), 1'b1, 1'b0, 1'b0);
    chk_taps("L4r_c3", 'h43, 'h33, 'h23, 'h13, 'h03);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("async_rst");
    dv_i = 1'b0; pix_i = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'd0, 1'b0, 1'b0, 1'b0);
    send_line(0, 8, 2, 'h02, rep('h02), rep('h02), rep('h02), rep('h02));
    send_line(1, 8, 2, 'h12, 'h02, rep('h02), rep('h02), rep('h02));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
